cond_flag_unit: RTL and testbench

//  Downstream companion of the ALU in the multicycle MCU. Registers the ALU result (ALUOut) and the

---
 rtl/cond_flag_unit_if.sv | 35 +++
 rtl/cond_flag_unit.sv | 79 +++++++
 tb/tb_cond_flag_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cond_flag_unit_if.sv
// Bus between the multicycle controller/ALU and the condition/flag unit.
// The master drives ALU results, decode controls and ungated strobes; the slave returns registered state and gated strobes.
interface cond_flag_unit_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      Result;
   logic [3:0]       ALUFlags;
   logic             ALUOutEn;
   logic [3:0]       Cond;
   logic             CondLatch;
   logic [1:0]       FlagW;
   logic             PCS;
   logic             RegW;
   logic             MemW;
   logic             NoWrite;
   logic [31:0]      ALUOut;
   logic [3:0]       Flags;
   logic             CondEx;
   logic             PCWrite;
   logic             RegWrite;
   logic             MemWrite;
   logic [CNT_W-1:0] SquashCnt;

   modport master (
      output Result, ALUFlags, ALUOutEn, Cond, CondLatch, FlagW,
             PCS, RegW, MemW, NoWrite,
      input  ALUOut, Flags, CondEx, PCWrite, RegWrite, MemWrite, SquashCnt
   );

   modport slave (
      input  Result, ALUFlags, ALUOutEn, Cond, CondLatch, FlagW,
             PCS, RegW, MemW, NoWrite,
      output ALUOut, Flags, CondEx, PCWrite, RegWrite, MemWrite, SquashCnt
   );
endinterface

// File: rtl/cond_flag_unit.sv
// Registers ALUOut and NZCV, evaluates the ARM condition field against stored flags,
// gates architectural write strobes and counts squashed instructions (saturating).
module cond_flag_unit #(
   parameter int CNT_W = 16
) (
   input logic             clk,
   input logic             rst_n,
   cond_flag_unit_if.slave bus
);

   logic [31:0]      alu_out_q, alu_out_d;
   logic [3:0]       flags_q, flags_d;
   logic             cond_q, cond_d;
   logic [CNT_W-1:0] squash_q, squash_d;
   logic             eval_now;
   logic             cond_ex;

   function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'h0:    eval_cond = z;
         4'h1:    eval_cond = ~z;
         4'h2:    eval_cond = c;
         4'h3:    eval_cond = ~c;
         4'h4:    eval_cond = n;
         4'h5:    eval_cond = ~n;
         4'h6:    eval_cond = v;
         4'h7:    eval_cond = ~v;
         4'h8:    eval_cond = c & ~z;
         4'h9:    eval_cond = ~c | z;
         4'hA:    eval_cond = (n == v);
         4'hB:    eval_cond = (n != v);
         4'hC:    eval_cond = ~z & (n == v);
         4'hD:    eval_cond = z | (n != v);
         default: eval_cond = 1'b1;
      endcase
   endfunction

   always_comb begin
      eval_now  = eval_cond(bus.Cond, flags_q);
      // Same-cycle bypass: the verdict is usable in Decode without waiting for cond_q
      cond_ex   = bus.CondLatch ? eval_now : cond_q;
      cond_d    = cond_ex;

      flags_d   = flags_q;
      if (bus.FlagW[1] && cond_ex) flags_d[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagW[0] && cond_ex) flags_d[1:0] = bus.ALUFlags[1:0];

      alu_out_d = bus.ALUOutEn ? bus.Result : alu_out_q;

      squash_d  = squash_q;
      if (bus.CondLatch && !eval_now && (squash_q != {CNT_W{1'b1}}))
         squash_d = squash_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_out_q <= 32'h0;
         flags_q   <= 4'h0;
         cond_q    <= 1'b1;
         squash_q  <= '0;
      end else begin
         alu_out_q <= alu_out_d;
         flags_q   <= flags_d;
         cond_q    <= cond_d;
         squash_q  <= squash_d;
      end
   end

   assign bus.ALUOut    = alu_out_q;
   assign bus.Flags     = flags_q;
   assign bus.CondEx    = cond_ex;
   assign bus.PCWrite   = bus.PCS & cond_ex;
   assign bus.RegWrite  = bus.RegW & cond_ex & ~bus.NoWrite;
   assign bus.MemWrite  = bus.MemW & cond_ex;
   assign bus.SquashCnt = squash_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: directed vector table, saturation/reset sequence and randomized
// traffic against a reference model; a CNT_W=4 copy shares the stimulus to exercise saturation.
module tb_cond_flag_unit;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cond_flag_unit_if #(.CNT_W(16)) bus16 ();
   cond_flag_unit_if #(.CNT_W(4))  bus4 ();

   cond_flag_unit #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
   cond_flag_unit #(.CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

   assign bus4.Result    = bus16.Result;
   assign bus4.ALUFlags  = bus16.ALUFlags;
   assign bus4.ALUOutEn  = bus16.ALUOutEn;
   assign bus4.Cond      = bus16.Cond;
   assign bus4.CondLatch = bus16.CondLatch;
   assign bus4.FlagW     = bus16.FlagW;
   assign bus4.PCS       = bus16.PCS;
   assign bus4.RegW      = bus16.RegW;
   assign bus4.MemW      = bus16.MemW;
   assign bus4.NoWrite   = bus16.NoWrite;

   typedef struct {
      logic        rst_n;
      logic [31:0] res;
      logic        aoe;
      logic [3:0]  alufl;
      logic [3:0]  cond;
      logic        latch;
      logic [1:0]  flagw;
      logic        pcs, regw, memw, nowr;
      logic        e_ce, e_pcw, e_rw, e_mw;
      logic [3:0]  e_flags;
      logic [31:0] e_alu;
      logic [3:0]  e_cnt;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // reference state
   bit          m_valid = 1'b0;
   logic [3:0]  m_flags = 4'h0;
   logic        m_cond  = 1'b1;
   int          m_cnt   = 0;
   logic [31:0] m_alu   = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Conditions come in complementary pairs: bit 0 inverts the base predicate of cond[3:1]
   function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v, base;
      n = f[3]; z = f[2]; cc = f[1]; v = f[0];
      if (c[3:1] == 3'd7) return 1'b1;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cc;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cc && !z;
         3'd5:    base = (n == v);
         default: base = !z && (n == v);
      endcase
      return c[0] ? !base : base;
   endfunction

   function automatic int clamp(input int x, input int mx);
      return (x > mx) ? mx : x;
   endfunction

   task automatic cycle(input vec_t v, input bit tab, input string tag);
      logic ev, ce;
      rst_n             = v.rst_n;
      bus16.Result      = v.res;
      bus16.ALUOutEn    = v.aoe;
      bus16.ALUFlags    = v.alufl;
      bus16.Cond        = v.cond;
      bus16.CondLatch   = v.latch;
      bus16.FlagW       = v.flagw;
      bus16.PCS         = v.pcs;
      bus16.RegW        = v.regw;
      bus16.MemW        = v.memw;
      bus16.NoWrite     = v.nowr;
      #1;
      ev = ref_eval(v.cond, m_flags);
      ce = v.latch ? ev : m_cond;
      if (m_valid) begin
         chk({tag, " CondEx"},   {31'b0, bus16.CondEx},   {31'b0, ce});
         chk({tag, " PCWrite"},  {31'b0, bus16.PCWrite},  {31'b0, v.pcs & ce});
         chk({tag, " RegWrite"}, {31'b0, bus16.RegWrite}, {31'b0, v.regw & ce & ~v.nowr});
         chk({tag, " MemWrite"}, {31'b0, bus16.MemWrite}, {31'b0, v.memw & ce});
         chk({tag, " CondEx4"},  {31'b0, bus4.CondEx},    {31'b0, ce});
      end
      if (tab) begin
         chk({tag, " tab CondEx"},   {31'b0, bus16.CondEx},   {31'b0, v.e_ce});
         chk({tag, " tab PCWrite"},  {31'b0, bus16.PCWrite},  {31'b0, v.e_pcw});
         chk({tag, " tab RegWrite"}, {31'b0, bus16.RegWrite}, {31'b0, v.e_rw});
         chk({tag, " tab MemWrite"}, {31'b0, bus16.MemWrite}, {31'b0, v.e_mw});
      end
      @(posedge clk);
      if (!v.rst_n) begin
         m_valid = 1'b1;
         m_flags = 4'h0;
         m_cond  = 1'b1;
         m_cnt   = 0;
         m_alu   = 32'h0;
      end else begin
         if (v.latch) m_cond = ev;
         if (v.latch && !ev) m_cnt++;
         if (v.flagw[1] && ce) m_flags[3:2] = v.alufl[3:2];
         if (v.flagw[0] && ce) m_flags[1:0] = v.alufl[1:0];
         if (v.aoe) m_alu = v.res;
      end
      #1;
      if (m_valid) begin
         chk({tag, " Flags"},  {28'b0, bus16.Flags}, {28'b0, m_flags});
         chk({tag, " ALUOut"}, bus16.ALUOut, m_alu);
         chk({tag, " Cnt16"},  {16'b0, bus16.SquashCnt}, clamp(m_cnt, 65535));
         chk({tag, " Cnt4"},   {28'b0, bus4.SquashCnt},  clamp(m_cnt, 15));
      end
      if (tab) begin
         chk({tag, " tab Flags"},  {28'b0, bus16.Flags}, {28'b0, v.e_flags});
         chk({tag, " tab ALUOut"}, bus16.ALUOut, v.e_alu);
         chk({tag, " tab Cnt4"},   {28'b0, bus4.SquashCnt}, {28'b0, v.e_cnt});
      end
   endtask

   vec_t tab[15];
   vec_t w;

   initial begin
      //          rst   result        aoe   alufl    cond  lat   flagw  pcs   regw  memw  nowr  ce    pcw   rw    mw    flags    alu           cnt
      tab[0]  = '{1'b0, 32'hFFFF_FFFF, 1'b1, 4'hF,    4'hF, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0,    32'h0000_0000, 4'h0};
      tab[1]  = '{1'b1, 32'h1234_5678, 1'b1, 4'h0,    4'hE, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,    32'h1234_5678, 4'h0};
      tab[2]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 4'b0110, 4'hE, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110, 32'h1234_5678, 4'h0};
      tab[3]  = '{1'b1, 32'hCAFE_F00D, 1'b1, 4'h0,    4'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 32'hCAFE_F00D, 4'h0};
      tab[4]  = '{1'b1, 32'h0000_0000, 1'b0, 4'h0,    4'h1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 32'hCAFE_F00D, 4'h1};
      tab[5]  = '{1'b1, 32'h0000_0000, 1'b0, 4'h0,    4'h0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 32'hCAFE_F00D, 4'h1};
      tab[6]  = '{1'b1, 32'h0000_0000, 1'b0, 4'hF,    4'hE, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF,    32'hCAFE_F00D, 4'h1};
      tab[7]  = '{1'b1, 32'h0000_0000, 1'b0, 4'h0,    4'h0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0011, 32'hCAFE_F00D, 4'h1};
      tab[8]  = '{1'b1, 32'h0000_0000, 1'b0, 4'hC,    4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 32'hCAFE_F00D, 4'h1};
      tab[9]  = '{1'b1, 32'h0000_0000, 1'b0, 4'b0100, 4'h0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 32'hCAFE_F00D, 4'h2};
      tab[10] = '{1'b1, 32'h0000_0000, 1'b0, 4'hF,    4'h0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 32'hCAFE_F00D, 4'h2};
      tab[11] = '{1'b1, 32'h0000_0000, 1'b0, 4'h0,    4'hC, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 32'hCAFE_F00D, 4'h3};
      tab[12] = '{1'b1, 32'h0000_0000, 1'b0, 4'h0,    4'hB, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0011, 32'hCAFE_F00D, 4'h3};
      tab[13] = '{1'b1, 32'h0000_0000, 1'b0, 4'h0,    4'h8, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 32'hCAFE_F00D, 4'h3};
      tab[14] = '{1'b1, 32'h0000_0000, 1'b0, 4'h0,    4'h9, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 32'hCAFE_F00D, 4'h4};

      for (int i = 0; i < 15; i++) cycle(tab[i], 1'b1, $sformatf("vec%0d", i));

      // 17 failing EQ pulses (Z=0): the 4-bit counter must pin at 4'hF
      w = tab[14];
      w.cond = 4'h0;
      for (int i = 0; i < 17; i++) cycle(w, 1'b0, "sat");
      chk("sat cnt4 pinned", {28'b0, bus4.SquashCnt}, 32'hF);
      chk("sat cnt16 count", {16'b0, bus16.SquashCnt}, 32'd21);

      // reset while cond_q holds a failing verdict
      w.rst_n = 1'b0;
      w.latch = 1'b0;
      cycle(w, 1'b0, "midrst");
      chk("midrst cnt4", {28'b0, bus4.SquashCnt}, 32'h0);
      chk("midrst cnt16", {16'b0, bus16.SquashCnt}, 32'h0);
      w.rst_n = 1'b1;
      w.pcs   = 1'b1;
      rst_n   = 1'b1;
      bus16.CondLatch = 1'b0;
      bus16.PCS       = 1'b1;
      #1;
      chk("midrst CondEx", {31'b0, bus16.CondEx}, 32'h1);
      chk("midrst PCWrite", {31'b0, bus16.PCWrite}, 32'h1);
      cycle(w, 1'b0, "postrst");

      for (int i = 0; i < 600; i++) begin
         w.rst_n = ($urandom_range(0, 63) != 0);
         w.res   = $urandom;
         w.aoe   = $urandom_range(0, 1) == 1;
         w.alufl = 4'($urandom_range(0, 15));
         w.cond  = 4'($urandom_range(0, 15));
         w.latch = $urandom_range(0, 2) == 0;
         w.flagw = 2'($urandom_range(0, 3));
         w.pcs   = $urandom_range(0, 1) == 1;
         w.regw  = $urandom_range(0, 1) == 1;
         w.memw  = $urandom_range(0, 1) == 1;
         w.nowr  = $urandom_range(0, 3) == 0;
         cycle(w, 1'b0, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
